irq_dispatch: RTL and testbench

IRQ_DISPATCH -- requirements
Module: irq_dispatch

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 28 ++
 rtl/irq_dispatch.sv | 162 ++++++++++++++++
 tb/tb_irq_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatcher: dispatch sequence states
// and default sizing.
package irq_pkg;

    localparam int         IRQ_N_DEFAULT = 5;
    localparam logic [7:0] IRQ_VEC_BASE  = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT1,
        ST_WAIT2,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_JUMP
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins, reported both
// one-hot and as a binary index.
module irq_prio_enc #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: IE register, master enable with delayed EI, and the
// fixed six-state push/jump sequence that vectors the CPU to a handler.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ST_IDLE    | no dispatch; evaluate pending at instr boundary/HALT
//   ST_WAIT1   | first stall cycle, ime already cleared
//   ST_WAIT2   | second stall cycle
//   ST_PUSH_HI | push PC high byte
//   ST_PUSH_LO | push PC low byte; winner latched on leaving
//   ST_JUMP    | load PC with vector, acknowledge winner
module irq_dispatch
    import irq_pkg::*;
#(
    parameter int         N_IRQ    = IRQ_N_DEFAULT,
    parameter logic [7:0] VEC_BASE = IRQ_VEC_BASE
) (
    input  logic             boga1mhz,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_trig,
    input  logic [7:0]       d_in,
    input  logic             ie_wr,
    output logic [N_IRQ-1:0] ie_q,
    input  logic             instr_done,
    input  logic             ei,
    input  logic             di,
    input  logic             reti,
    input  logic             halted,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             busy,
    output logic             push_hi,
    output logic             push_lo,
    output logic             jump,
    output logic [7:0]       vector,
    output logic             wake,
    output logic             ime
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_e       state_q, state_d;
    logic [N_IRQ-1:0] ie_d;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] enc_oh;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic             any_pend;
    logic [N_IRQ-1:0] win_oh_q, win_oh_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic             ime_q, ime_d;
    logic             ei_arm_q, ei_arm_d;
    logic             start;
    logic             strobe_ok;
    logic             out_en;
    logic [7:0]       win_vec;

    assign pending  = irq_trig & ie_q;
    assign any_pend = enc_valid;

    irq_prio_enc #(
        .N     (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req    (pending),
        .onehot (enc_oh),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    generate
        if (N_IRQ < 8) begin : g_d_in_spare
            logic unused_d_in;
            assign unused_d_in = ^d_in[7:N_IRQ];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((instr_done || halted) && ime_q && any_pend) begin
                    start   = 1'b1;
                    state_d = ST_WAIT1;
                end
            end
            ST_WAIT1:   state_d = ST_WAIT2;
            ST_WAIT2:   state_d = ST_PUSH_HI;
            ST_PUSH_HI: state_d = ST_PUSH_LO;
            ST_PUSH_LO: state_d = ST_JUMP;
            ST_JUMP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ei/di/reti only count at an instruction boundary outside a dispatch.
    assign strobe_ok = instr_done && (state_q == ST_IDLE);

    always_comb begin
        ie_d      = ie_wr ? d_in[N_IRQ-1:0] : ie_q;
        ime_d     = ime_q;
        ei_arm_d  = ei_arm_q;
        win_oh_d  = win_oh_q;
        win_idx_d = win_idx_q;
        if (strobe_ok) begin
            if (di) begin
                ime_d    = 1'b0;
                ei_arm_d = 1'b0;
            end else begin
                if (ei_arm_q) begin
                    ime_d    = 1'b1;
                    ei_arm_d = 1'b0;
                end
                if (reti) begin
                    ime_d = 1'b1;
                end
                if (ei) begin
                    ei_arm_d = 1'b1;
                end
            end
        end
        if (start) begin
            ime_d = 1'b0;
        end
        if (state_q == ST_PUSH_LO) begin
            win_oh_d  = enc_oh;
            win_idx_d = enc_idx;
        end
    end

    always_ff @(posedge boga1mhz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ie_q      <= '0;
            ime_q     <= 1'b0;
            ei_arm_q  <= 1'b0;
            win_oh_q  <= '0;
            win_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            ime_q     <= ime_d;
            ei_arm_q  <= ei_arm_d;
            win_oh_q  <= win_oh_d;
            win_idx_q <= win_idx_d;
        end
    end

    // Strobes are held low while reset is asserted so an aborted dispatch
    // emits nothing in the reset cycle itself.
    assign out_en  = !reset;
    assign busy    = (state_q != ST_IDLE);
    assign push_hi = out_en && (state_q == ST_PUSH_HI);
    assign push_lo = out_en && (state_q == ST_PUSH_LO);
    assign jump    = out_en && (state_q == ST_JUMP);
    assign win_vec = VEC_BASE + (8'(win_idx_q) << 3);
    assign irq_ack = jump ? win_oh_q : '0;
    assign vector  = (jump && (|win_oh_q)) ? win_vec : 8'h00;
    assign wake    = halted && any_pend;
    assign ime     = ime_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: directed scenarios with literal
// expectations plus randomized traffic compared against a cycle-count model.
module tb_irq_dispatch;

    logic       boga1mhz = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] irq_trig = '0;
    logic [7:0] d_in = '0;
    logic       ie_wr = 1'b0;
    logic [4:0] ie_q;
    logic       instr_done = 1'b0;
    logic       ei = 1'b0;
    logic       di = 1'b0;
    logic       reti = 1'b0;
    logic       halted = 1'b0;
    logic [4:0] irq_ack;
    logic       busy, push_hi, push_lo, jump, wake, ime;
    logic [7:0] vector;

    int n_checks = 0;
    int n_fail = 0;

    // Model state: phase counts cycles since the dispatch decision (0 = none).
    logic [4:0] m_ie = '0;
    bit         m_ime = 1'b0;
    bit         m_armed = 1'b0;
    int         m_phase = 0;
    int         m_win = -1;
    bit         model_ok = 1'b0;

    irq_dispatch dut (
        .boga1mhz   (boga1mhz),
        .reset      (reset),
        .irq_trig   (irq_trig),
        .d_in       (d_in),
        .ie_wr      (ie_wr),
        .ie_q       (ie_q),
        .instr_done (instr_done),
        .ei         (ei),
        .di         (di),
        .reti       (reti),
        .halted     (halted),
        .irq_ack    (irq_ack),
        .busy       (busy),
        .push_hi    (push_hi),
        .push_lo    (push_lo),
        .jump       (jump),
        .vector     (vector),
        .wake       (wake),
        .ime        (ime)
    );

    always #5 boga1mhz = ~boga1mhz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [4:0] pend;
        bit         go;
        bit         n_ime;
        bit         n_armed;
        if (reset) begin
            m_ie     = '0;
            m_ime    = 1'b0;
            m_armed  = 1'b0;
            m_phase  = 0;
            m_win    = -1;
            model_ok = 1'b1;
            return;
        end
        pend    = irq_trig & m_ie;
        go      = (m_phase == 0) && (instr_done || halted) && m_ime && (pend != 0);
        n_ime   = m_ime;
        n_armed = m_armed;
        if (m_phase == 0 && instr_done) begin
            if (di) begin
                n_ime   = 1'b0;
                n_armed = 1'b0;
            end else begin
                if (m_armed) begin
                    n_ime   = 1'b1;
                    n_armed = 1'b0;
                end
                if (reti) n_ime = 1'b1;
                if (ei) n_armed = 1'b1;
            end
        end
        if (go) n_ime = 1'b0;
        if (m_phase == 4) m_win = lowest(pend);
        if (m_phase == 0) m_phase = go ? 1 : 0;
        else if (m_phase == 5) m_phase = 0;
        else m_phase = m_phase + 1;
        m_ime   = n_ime;
        m_armed = n_armed;
        if (ie_wr) m_ie = d_in[4:0];
    endtask

    task automatic compare_all();
        bit         e_jump;
        logic [4:0] e_ack;
        logic [7:0] e_vec;
        e_jump = !reset && (m_phase == 5);
        e_ack  = (e_jump && m_win >= 0) ? 5'(1 << m_win) : 5'd0;
        e_vec  = (e_jump && m_win >= 0) ? 8'(8'h40 + 8 * m_win) : 8'h00;
        chk("busy", busy, m_phase != 0);
        chk("push_hi", push_hi, !reset && (m_phase == 3));
        chk("push_lo", push_lo, !reset && (m_phase == 4));
        chk("jump", jump, e_jump);
        chk("irq_ack", irq_ack, e_ack);
        chk("vector", vector, e_vec);
        chk("wake", wake, halted && ((irq_trig & m_ie) != 0));
        chk("ie_q", ie_q, m_ie);
        chk("ime", ime, m_ime);
    endtask

    initial begin
        forever begin
            @(posedge boga1mhz);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge boga1mhz);
            if (model_ok) compare_all();
        end
    end

    task automatic step();
        @(posedge boga1mhz);
        #1;
        instr_done = 1'b0;
        ei         = 1'b0;
        di         = 1'b0;
        reti       = 1'b0;
        ie_wr      = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        irq_trig = '0;
        halted   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write_ie(input logic [7:0] v);
        ie_wr = 1'b1;
        d_in  = v;
        step();
    endtask

    task automatic set_ime();
        instr_done = 1'b1;
        reti       = 1'b1;
        step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        step();
        @(negedge boga1mhz);
        chk("rst busy", busy, 0);
        chk("rst ie_q", ie_q, 0);
        chk("rst ime", ime, 0);
        chk("rst jump", jump, 0);
        chk("rst vector", vector, 8'h00);
        do_reset();

        // prio 2 of 10100, full timing
        write_ie(8'h1F);
        set_ime();
        irq_trig   = 5'b10100;
        instr_done = 1'b1;
        @(negedge boga1mhz);
        chk("t1 c0 busy", busy, 0);
        step();
        @(negedge boga1mhz);
        chk("t1 c1 busy", busy, 1);
        chk("t1 c1 ime", ime, 0);
        chk("t1 c1 push_hi", push_hi, 0);
        steps(2);
        @(negedge boga1mhz);
        chk("t1 c3 push_hi", push_hi, 1);
        step();
        @(negedge boga1mhz);
        chk("t1 c4 push_lo", push_lo, 1);
        step();
        @(negedge boga1mhz);
        chk("t1 c5 jump", jump, 1);
        chk("t1 c5 vector", vector, 8'h50);
        chk("t1 c5 irq_ack", irq_ack, 5'b00100);
        chk("t1 c5 ime", ime, 0);
        step();
        @(negedge boga1mhz);
        chk("t1 c6 busy", busy, 0);

        // IE cleared during WAIT2 -> empty jump
        do_reset();
        write_ie(8'h01);
        set_ime();
        irq_trig   = 5'b00001;
        instr_done = 1'b1;
        steps(2);
        ie_wr = 1'b1;
        d_in  = 8'h00;
        steps(3);
        @(negedge boga1mhz);
        chk("t2 jump", jump, 1);
        chk("t2 vector", vector, 8'h00);
        chk("t2 irq_ack", irq_ack, 5'b00000);

        // ei delay
        do_reset();
        write_ie(8'h1F);
        irq_trig   = 5'b00001;
        instr_done = 1'b1;
        ei         = 1'b1;
        step();
        instr_done = 1'b1;
        @(negedge boga1mhz);
        chk("t3 k+1 busy", busy, 0);
        chk("t3 k+1 ime", ime, 0);
        step();
        instr_done = 1'b1;
        @(negedge boga1mhz);
        chk("t3 k+2 ime", ime, 1);
        chk("t3 k+2 busy", busy, 0);
        step();
        @(negedge boga1mhz);
        chk("t3 k+3 busy", busy, 1);
        steps(6);

        // ei cancelled by di
        do_reset();
        write_ie(8'h1F);
        irq_trig   = 5'b00001;
        instr_done = 1'b1;
        ei         = 1'b1;
        step();
        instr_done = 1'b1;
        di         = 1'b1;
        step();
        instr_done = 1'b1;
        step();
        @(negedge boga1mhz);
        chk("t4 busy", busy, 0);
        chk("t4 ime", ime, 0);

        // wake without ime
        do_reset();
        write_ie(8'h04);
        halted   = 1'b1;
        irq_trig = 5'b00100;
        @(negedge boga1mhz);
        chk("t5 wake", wake, 1);
        step();
        @(negedge boga1mhz);
        chk("t5 busy", busy, 0);
        halted = 1'b0;

        // reset in PUSH_LO
        do_reset();
        write_ie(8'h1F);
        set_ime();
        irq_trig   = 5'b00001;
        instr_done = 1'b1;
        steps(4);
        reset = 1'b1;
        @(negedge boga1mhz);
        chk("t6 rst push_lo", push_lo, 0);
        chk("t6 rst jump", jump, 0);
        step();
        reset = 1'b0;
        @(negedge boga1mhz);
        chk("t6 busy", busy, 0);
        chk("t6 jump", jump, 0);
        chk("t6 irq_ack", irq_ack, 0);
        chk("t6 ie_q", ie_q, 0);

        // lowest index among 11110
        do_reset();
        write_ie(8'h1E);
        set_ime();
        irq_trig   = 5'b11111;
        instr_done = 1'b1;
        steps(5);
        @(negedge boga1mhz);
        chk("t7 vector", vector, 8'h48);
        chk("t7 irq_ack", irq_ack, 5'b00010);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) irq_trig = 5'($urandom);
            instr_done = ($urandom_range(0, 1) == 1);
            if (instr_done) begin
                ei   = ($urandom_range(0, 9) == 0);
                di   = ($urandom_range(0, 11) == 0);
                reti = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 15) == 0) halted = ~halted;
            if ($urandom_range(0, 19) == 0) begin
                ie_wr = 1'b1;
                d_in  = 8'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        steps(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
